// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch (IF) and data access (MEM).
// Define RAM_ARB_PERF_EN to add grant/conflict performance counters.
module ram_port_arbiter #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ack_o,
    output logic              mem_rvalid_o,
    output logic [DATA_W-1:0] mem_rdata_o,
`ifdef RAM_ARB_PERF_EN
    output logic [31:0]       perf_if_grants_o,
    output logic [31:0]       perf_mem_grants_o,
    output logic [31:0]       perf_conflicts_o,
`endif
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_wen_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnMem} owner_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    owner_e     rd_owner_q, rd_owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       if_gnt, mem_gnt;

    // Grants are suppressed while rst is high so every ram_* output reads 0 in reset.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (if_req_i && (!mem_req_i || starve_cnt_q == StarveMax)) begin
                if_gnt = 1'b1;
            end else if (mem_req_i) begin
                mem_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        rd_owner_d = OwnNone;
        if (if_gnt) begin
            rd_owner_d = OwnIf;
        end else if (mem_gnt && !mem_we_i) begin
            rd_owner_d = OwnMem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q   <= OwnNone;
            starve_cnt_q <= 4'd0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        ram_en_o    = if_gnt | mem_gnt;
        ram_wen_o   = mem_gnt & mem_we_i;
        ram_raddr_o = '0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        if (if_gnt) begin
            ram_raddr_o = if_addr_i;
        end else if (mem_gnt && mem_we_i) begin
            ram_waddr_o = mem_addr_i;
            ram_wdata_o = mem_wdata_i;
        end else if (mem_gnt) begin
            ram_raddr_o = mem_addr_i;
        end
    end

    // Read data is steered by the registered owner, not by this cycle's grant.
    assign if_ack_o     = if_gnt;
    assign mem_ack_o    = mem_gnt;
    assign if_rvalid_o  = (rd_owner_q == OwnIf);
    assign mem_rvalid_o = (rd_owner_q == OwnMem);
    assign if_rdata_o   = if_rvalid_o  ? ram_rdata_i : '0;
    assign mem_rdata_o  = mem_rvalid_o ? ram_rdata_i : '0;

`ifdef RAM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_grants_o  <= 32'd0;
            perf_mem_grants_o <= 32'd0;
            perf_conflicts_o  <= 32'd0;
        end else begin
            if (if_gnt) perf_if_grants_o <= perf_if_grants_o + 32'd1;
            if (mem_gnt) perf_mem_grants_o <= perf_mem_grants_o + 32'd1;
            if (if_req_i && mem_req_i) perf_conflicts_o <= perf_conflicts_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (STARVE_MAX = 4).
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, if_ack_o, if_rvalid_o;
    logic [63:0] if_addr_i, if_rdata_o;
    logic        mem_req_i, mem_we_i, mem_ack_o, mem_rvalid_o;
    logic [63:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic        ram_en_o, ram_wen_o;
    logic [63:0] ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_rdata_i;
`ifdef RAM_ARB_PERF_EN
    logic [31:0] perf_if_grants_o, perf_mem_grants_o, perf_conflicts_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_W(64), .ADDR_W(64), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_ack_o     (if_ack_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_ack_o    (mem_ack_o),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_rdata_o  (mem_rdata_o),
`ifdef RAM_ARB_PERF_EN
        .perf_if_grants_o  (perf_if_grants_o),
        .perf_mem_grants_o (perf_mem_grants_o),
        .perf_conflicts_o  (perf_conflicts_o),
`endif
        .ram_en_o     (ram_en_o),
        .ram_raddr_o  (ram_raddr_o),
        .ram_waddr_o  (ram_waddr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_wen_o    (ram_wen_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow a settle delay.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req_i = 1'b1; if_addr_i = 64'h40;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h80; mem_wdata_i = '0;
        ram_rdata_i = 64'h1234;
        #2;
        chk("rst_ram_en", ram_en_o, 0);
        chk("rst_if_ack", if_ack_o, 0);
        chk("rst_mem_ack", mem_ack_o, 0);
        chk("rst_raddr", ram_raddr_o, 0);
        chk("rst_if_rvalid", if_rvalid_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        if_req_i = 1'b0; mem_req_i = 1'b0; ram_rdata_i = '0;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("idle_ram_en", ram_en_o, 0);
        chk("idle_mem_rvalid", mem_rvalid_o, 0);

        // IF-only read
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 64'h1c000000;
        #1;
        chk("if_ack", if_ack_o, 1);
        chk("if_ram_en", ram_en_o, 1);
        chk("if_raddr", ram_raddr_o, 64'h1c000000);
        chk("if_wen", ram_wen_o, 0);
        chk("if_mem_ack", mem_ack_o, 0);
        next_cycle();
        if_req_i = 1'b0; ram_rdata_i = 64'hdeadbeef;
        #1;
        chk("if_rvalid", if_rvalid_o, 1);
        chk("if_rdata", if_rdata_o, 64'hdeadbeef);
        chk("if_mem_rvalid", mem_rvalid_o, 0);
        chk("if_mem_rdata", mem_rdata_o, 0);
        chk("if_idle_en", ram_en_o, 0);

        // MEM write beats a pending IF request
        next_cycle();
        ram_rdata_i = '0;
        if_req_i = 1'b1; if_addr_i = 64'h100;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 64'h1c000010; mem_wdata_i = 64'h55;
        #1;
        chk("wr_mem_ack", mem_ack_o, 1);
        chk("wr_if_ack", if_ack_o, 0);
        chk("wr_wen", ram_wen_o, 1);
        chk("wr_en", ram_en_o, 1);
        chk("wr_waddr", ram_waddr_o, 64'h1c000010);
        chk("wr_wdata", ram_wdata_o, 64'h55);
        chk("wr_raddr", ram_raddr_o, 0);
        next_cycle();
        if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; ram_rdata_i = 64'hbad;
        #1;
        chk("wr_no_if_rvalid", if_rvalid_o, 0);
        chk("wr_no_mem_rvalid", mem_rvalid_o, 0);
        chk("wr_mem_rdata", mem_rdata_o, 0);

        // Back-to-back IF read then MEM read
        next_cycle();
        ram_rdata_i = '0;
        if_req_i = 1'b1; if_addr_i = 64'h200;
        #1;
        chk("b2b_if_ack", if_ack_o, 1);
        chk("b2b_en0", ram_en_o, 1);
        next_cycle();
        if_req_i = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h300; ram_rdata_i = 64'h111;
        #1;
        chk("b2b_mem_ack", mem_ack_o, 1);
        chk("b2b_en1", ram_en_o, 1);
        chk("b2b_raddr1", ram_raddr_o, 64'h300);
        chk("b2b_if_rvalid", if_rvalid_o, 1);
        chk("b2b_if_rdata", if_rdata_o, 64'h111);
        chk("b2b_mem_rvalid0", mem_rvalid_o, 0);
        next_cycle();
        mem_req_i = 1'b0; ram_rdata_i = 64'h222;
        #1;
        chk("b2b_mem_rvalid", mem_rvalid_o, 1);
        chk("b2b_mem_rdata", mem_rdata_o, 64'h222);
        chk("b2b_if_rvalid2", if_rvalid_o, 0);
        chk("b2b_if_rdata2", if_rdata_o, 0);

        // Anti-starvation: MEM wins cycles 0-3, IF cycle 4, MEM again cycle 5
        next_cycle();
        ram_rdata_i = '0;
        if_req_i = 1'b1; if_addr_i = 64'h400;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h500;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("starve_if_ack_c%0d", c), if_ack_o, (c == 4) ? 1 : 0);
            chk($sformatf("starve_mem_ack_c%0d", c), mem_ack_o, (c == 4) ? 0 : 1);
            chk($sformatf("starve_raddr_c%0d", c), ram_raddr_o, (c == 4) ? 64'h400 : 64'h500);
            next_cycle();
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;

        // Reset right after an IF read issue drops the response
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 64'h600;
        #1;
        chk("rr_if_ack", if_ack_o, 1);
        next_cycle();
        if_req_i = 1'b0; rst = 1'b1;
        mem_req_i = 1'b1; mem_addr_i = 64'h700; ram_rdata_i = 64'h999;
        #1;
        chk("rr_if_rvalid_in_rst", if_rvalid_o, 0);
        chk("rr_ram_en_in_rst", ram_en_o, 0);
        chk("rr_raddr_in_rst", ram_raddr_o, 0);
        chk("rr_mem_ack_in_rst", mem_ack_o, 0);
        next_cycle();
        rst = 1'b0; mem_req_i = 1'b0;
        #1;
        chk("rr_if_rvalid_post", if_rvalid_o, 0);
        chk("rr_if_rdata_post", if_rdata_o, 0);
        next_cycle();
        chk("rr_if_rvalid_post2", if_rvalid_o, 0);

`ifdef RAM_ARB_PERF_EN
        // Counters are clean after the reset above: 3 IF-only grants, then 2 conflicts won by MEM
        chk("perf_if_reset", perf_if_grants_o, 0);
        if_req_i = 1'b1; if_addr_i = 64'h800;
        for (int c = 0; c < 3; c++) next_cycle();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h900;
        #1;
        chk("perf_conflict_mem_ack", mem_ack_o, 1);
        next_cycle();
        next_cycle();
        if_req_i = 1'b0; mem_req_i = 1'b0;
        #1;
        chk("perf_if_grants", perf_if_grants_o, 3);
        chk("perf_mem_grants", perf_mem_grants_o, 2);
        chk("perf_conflicts", perf_conflicts_o, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous RAM port (one read address, one write address, enable, write-enable) between two requesters inside cpu_top: instruction fetch (IF) and data memory access (MEM).
- Sits between the pipeline's fetch/LSU stages and the ram_*_o interface of cpu_top.
- Arbitrates one operation per cycle: MEM has fixed priority, with anti-starvation for IF.
- Tracks the owner of the outstanding read so the 1-cycle-latency read data is routed back to the correct requester.

Parameters:
- DATA_W, 64, RAM data width (`RegBus`).
- ADDR_W, 64, RAM byte-address width.
- STARVE_MAX, 4, consecutive IF-denied cycles after which IF is forced to win one grant (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  IF read request; held stable until if_ack_o
- if_addr_i  in  ADDR_W  IF read address
- if_ack_o  out  1  IF request issued to RAM this cycle
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  DATA_W  IF read data
- mem_req_i  in  1  MEM request; held stable until mem_ack_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  ADDR_W  MEM address
- mem_wdata_i  in  DATA_W  MEM write data
- mem_ack_o  out  1  MEM request issued to RAM this cycle
- mem_rvalid_o  out  1  MEM read data valid
- mem_rdata_o  out  DATA_W  MEM read data
- ram_en_o  out  1  RAM chip enable
- ram_raddr_o  out  ADDR_W  RAM read address
- ram_waddr_o  out  ADDR_W  RAM write address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_wen_o  out  1  RAM write enable
- ram_rdata_i  in  DATA_W  RAM read data, valid the cycle after a read issue

Behaviour:
- RAM timing:
  - Read issued in cycle N (ram_en_o=1, ram_wen_o=0) returns ram_rdata_i in cycle N+1.
  - Write completes in its issue cycle.
  - Port is fully pipelined; a new operation may issue in the same cycle a previous read's data returns.
- Grant (combinational, every cycle):
  - Only IF requests → IF wins.
  - Only MEM requests → MEM wins.
  - Both request → MEM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - Exactly one ack per cycle; ack is asserted in the issue cycle.
- Issue outputs:
  - IF grant: ram_en_o=1, ram_raddr_o=if_addr_i, ram_wen_o=0.
  - MEM read: ram_en_o=1, ram_raddr_o=mem_addr_i, ram_wen_o=0.
  - MEM write: ram_en_o=1, ram_wen_o=1, ram_waddr_o=mem_addr_i, ram_wdata_o=mem_wdata_i; ram_raddr_o=0.
  - No grant: all ram_* outputs are 0.
- Owner register rd_owner, states NONE / IF / MEM:
  - Next state = IF on IF grant, MEM on MEM read grant, NONE otherwise (including writes).
  - if_rvalid_o = (rd_owner==IF); mem_rvalid_o = (rd_owner==MEM).
  - Both rdata outputs carry ram_rdata_i when their rvalid is high, 0 otherwise.
- starve_cnt (4-bit):
  - Increments when if_req_i=1 and IF is not granted; saturates at STARVE_MAX.
  - Clears on IF grant, or when if_req_i=0.
- Write-data response: no rvalid is produced for a write.
- Reset values: rd_owner=NONE, starve_cnt=0. All outputs are 0 during and immediately after reset.
- Reset mid-operation: the outstanding read is dropped and no rvalid is produced after rst deasserts. Requesters must re-issue.
- Simultaneous events: response of read N and issue of read N+1 in the same cycle is legal. rdata routing uses the registered owner, not the current grant.

Optional Feature:
- Macro RAM_ARB_PERF_EN.
- Defined: adds three 32-bit wrapping counters, each exposed as an output port.
  - perf_if_grants_o: counts IF grants.
  - perf_mem_grants_o: counts MEM grants.
  - perf_conflicts_o: counts cycles where both requesters asserted req.
  - All counters clear on rst.
- Undefined: the counters and their ports are absent; the rest of the block is unchanged.

Test Plan:
- IF-only read of addr 0x1c000000, ram_rdata_i=0xdeadbeef next cycle → if_ack_o=1 in cycle 0; if_rvalid_o=1 and if_rdata_o=0xdeadbeef in cycle 1; mem_rvalid_o=0.
- MEM write to 0x1c000010 with data 0x55 while if_req_i=1 → mem_ack_o=1, ram_wen_o=1, ram_waddr_o=0x1c000010; if_ack_o=0; no rvalid next cycle.
- Back-to-back reads: IF at cycle 0, MEM read at cycle 1 → rdata in cycle 1 routed to IF; rdata in cycle 2 routed to MEM; ram_en_o=1 on both issue cycles.
- Continuous MEM read requests plus continuous IF request, STARVE_MAX=4 → MEM is granted for cycles 0–3, IF is granted in cycle 4, MEM resumes in cycle 5.
- Assert rst in the cycle after an IF read issue → no if_rvalid_o after reset release; all ram_* outputs are 0 while rst=1.
- With RAM_ARB_PERF_EN: 3 IF-only grants plus 2 conflict cycles won by MEM → perf_if_grants_o=3, perf_mem_grants_o=2, perf_conflicts_o=2.
